nonce_result_scan: RTL

NONCE_RESULT_SCAN -- requirements
Module: nonce_result_scan

---
 rtl/nonce_result_scan.sv | 117 +++++++++++
 1 files changed

// File: rtl/nonce_result_scan.sv
// Scans NUM_NONCES hash words from memory. It tracks the minimum word and counts the words
// strictly below target, then writes a two-word report back to memory.
module nonce_result_scan #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] result_addr,
  input  logic [31:0] report_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic [8:0]  match_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam int CW = 10;
  localparam logic [CW-1:0] LAST_ADDR = CW'(NUM_NONCES - 1);
  localparam logic [CW-1:0] LAST_CAP  = CW'(NUM_NONCES + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   base, rep;
  logic [31:0]   tgt;
  logic [1:0]    wph;

  logic unused_hi;
  assign unused_hi = ^{result_addr[31:16], report_addr[31:16]};

  assign mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      base           <= '0;
      rep            <= '0;
      tgt            <= '0;
      wph            <= '0;
      done           <= 1'b0;
      found          <= 1'b0;
      best_nonce     <= '0;
      best_hash      <= 32'hFFFF_FFFF;
      match_count    <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= READ;
            cnt         <= CW'(1);
            base        <= result_addr[15:0];
            rep         <= report_addr[15:0];
            tgt         <= target;
            done        <= 1'b0;
            found       <= 1'b0;
            match_count <= '0;
            best_nonce  <= '0;
            best_hash   <= 32'hFFFF_FFFF;
            mem_addr    <= result_addr[15:0];
            mem_we      <= 1'b0;
          end
        end
        READ: begin
          // Address issue runs two edges ahead of capture to cover read latency.
          if (cnt <= LAST_ADDR) mem_addr <= base + 16'(cnt);
          if (cnt >= CW'(2)) begin
            if (mem_read_data < tgt) begin
              found       <= 1'b1;
              match_count <= match_count + 9'd1;
            end
            if (mem_read_data < best_hash) begin
              best_hash  <= mem_read_data;
              best_nonce <= 8'(cnt - CW'(2));
            end
          end
          if (cnt == LAST_CAP) begin
            state <= WRITE;
            wph   <= '0;
          end
          cnt <= cnt + CW'(1);
        end
        WRITE: begin
          case (wph)
            2'd0: begin
              mem_we         <= 1'b1;
              mem_addr       <= rep;
              mem_write_data <= {found, 23'b0, best_nonce};
              wph            <= 2'd1;
            end
            2'd1: begin
              mem_addr       <= rep + 16'd1;
              mem_write_data <= best_hash;
              wph            <= 2'd2;
            end
            default: begin
              mem_we <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
